// File: rtl/dmac_pkg.sv
// dmac_pkg: shared state encoding, direction constants and data width default
// for the DMAC I/O port device model.
package dmac_pkg;
    localparam int DATA_W_DEF = 8;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_XFER = 2'd2;
    localparam logic [1:0] S_TERM = 2'd3;
    localparam logic DIR_SRC = 1'b0;
    localparam logic DIR_SNK = 1'b1;
endpackage

// File: rtl/dma_io_port_if.sv
// dma_io_port_if: DREQ/DACK handshake and data bytes between the DMAC (master)
// and the I/O device (slave).
interface dma_io_port_if import dmac_pkg::*; #(parameter int DATA_W = DATA_W_DEF);
    logic              dreq;
    logic              dack;
    logic              ior;
    logic              iow;
    logic              eop;
    logic [DATA_W-1:0] io_dout;
    logic [DATA_W-1:0] io_din;
    modport master (output dack, ior, iow, eop, io_din, input dreq, io_dout);
    modport slave  (input dack, ior, iow, eop, io_din, output dreq, io_dout);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: circular-buffer FIFO whose head output holds its last value while
// empty; the caller only issues legal push/pop combinations.
module sync_fifo import dmac_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o,
    output logic [CNT_W-1:0]  cnt_nx_o
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q, rd_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] last_q;
    assign full_o   = cnt_q == CNT_W'(DEPTH);
    assign empty_o  = cnt_q == '0;
    assign count_o  = cnt_q;
    assign cnt_nx_o = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
    // Push and pop on an empty FIFO pass the incoming byte straight through.
    assign head_o   = !empty_o ? mem_q[rd_q] : (push_i & pop_i) ? din_i : last_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            last_q <= '0;
        end else begin
            wr_q   <= push_i ? wr_q + 1'b1 : wr_q;
            rd_q   <= pop_i ? rd_q + 1'b1 : rd_q;
            cnt_q  <= cnt_nx_o;
            last_q <= head_o;
        end
    end
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end
endmodule

// File: rtl/dma_io_port.sv
// dma_io_port: peripheral end of the DMAC DREQ/DACK handshake; buffers bytes in a
// FIFO and sources them on IOR (DIR=0) or sinks them on IOW (DIR=1).
module dma_io_port import dmac_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              dir_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    dma_io_port_if.slave      dma,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              done_o,
    output logic              err_o
);
    logic [1:0]        state_q, state_d;
    logic              dir_q, dreq_q, dreq_d, done_q, err_q;
    logic              snk, stb, svc, svc_nx;
    logic              push_req, pop_req, push_ok, pop_ok, pop_src, push_snk, err_set;
    logic [CNT_W-1:0]  cnt_nx;
    logic [DATA_W-1:0] head;
    // DIR is live while idle so the local side can pre-load or drain the FIFO.
    assign snk      = (state_q == S_IDLE ? dir_i : dir_q) == DIR_SNK;
    assign stb      = state_q == S_XFER && dma.dack && (snk ? dma.iow : dma.ior);
    assign push_req = snk ? stb : wr_en_i;
    assign pop_req  = snk ? rd_en_i : stb;
    assign pop_src  = pop_req & !empty_o;
    assign push_snk = push_req & !full_o;
    // Full source / empty sink accept a simultaneous push and pop; DMAC side first.
    assign push_ok  = snk ? push_snk : push_req & (!full_o | pop_src);
    assign pop_ok   = snk ? pop_req & (!empty_o | push_snk) : pop_src;
    assign err_set  = (push_req & !push_ok) | (pop_req & !pop_ok);
    assign svc      = snk ? !full_o : !empty_o;
    assign svc_nx   = snk ? cnt_nx != CNT_W'(DEPTH) : cnt_nx != '0;
    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_i   (push_ok),
        .pop_i    (pop_ok),
        .din_i    (snk ? dma.io_din : wr_data_i),
        .head_o   (head),
        .full_o   (full_o),
        .empty_o  (empty_o),
        .count_o  (count_o),
        .cnt_nx_o (cnt_nx)
    );
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = (en_i & svc) ? S_REQ : S_IDLE;
            S_REQ:   state_d = dma.eop ? S_TERM : !en_i ? S_IDLE : dma.dack ? S_XFER : S_REQ;
            S_XFER:  state_d = dma.eop ? S_TERM : !dma.dack ? S_REQ : S_XFER;
            default: state_d = en_i ? S_TERM : S_IDLE;
        endcase
        dreq_d = (state_d == S_REQ || state_d == S_XFER) && svc_nx;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dir_q   <= DIR_SRC;
            dreq_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= state_q == S_IDLE ? dir_i : dir_q;
            dreq_q  <= dreq_d;
            done_q  <= state_d == S_TERM;
            err_q   <= (state_d == S_IDLE && state_q != S_IDLE) ? 1'b0 : err_q | err_set;
        end
    end
    assign dma.dreq    = dreq_q;
    assign dma.io_dout = head;
    assign rd_data_o   = head;
    assign done_o      = done_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_dma_io_port.sv
// tb_dma_io_port: directed bench; expected output bytes are queued at stimulus time
// and a negedge monitor compares them whenever a strobe or local pop is active.
module tb_dma_io_port;
    import dmac_pkg::*;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, dir = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic [7:0] rd_data;
    logic       full, empty, done, err;
    logic [2:0] count;
    logic [7:0] exp_io[$];
    logic [7:0] exp_rd[$];
    int total = 0;
    int bad = 0;
    dma_io_port_if ifc ();
    dma_io_port dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (en),
        .dir_i     (dir),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_en),
        .dma       (ifc),
        .rd_data_o (rd_data),
        .full_o    (full),
        .empty_o   (empty),
        .count_o   (count),
        .done_o    (done),
        .err_o     (err)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (rst_n) begin
            if (ifc.dack && ifc.ior) begin
                if (exp_io.size() == 0) chk("io_dout_unexpected", 1, 0);
                else chk("io_dout", ifc.io_dout, exp_io.pop_front());
            end
            if (rd_en) begin
                if (exp_rd.size() == 0) chk("rd_data_unexpected", 1, 0);
                else chk("rd_data", rd_data, exp_rd.pop_front());
            end
        end
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic push_local(input logic [7:0] b);
        wr_en = 1'b1; wr_data = b;
        tick();
        wr_en = 1'b0;
    endtask
    task automatic local_pop(input logic [7:0] e);
        rd_en = 1'b1; exp_rd.push_back(e);
        tick();
        rd_en = 1'b0;
    endtask
    task automatic strobe_rd(input logic [7:0] e, input logic eo = 1'b0);
        ifc.dack = 1'b1; ifc.ior = 1'b1; ifc.eop = eo; exp_io.push_back(e);
        tick();
        ifc.ior = 1'b0; ifc.eop = 1'b0;
    endtask
    task automatic strobe_wr(input logic [7:0] b);
        ifc.dack = 1'b1; ifc.iow = 1'b1; ifc.io_din = b;
        tick();
        ifc.iow = 1'b0;
    endtask
    task automatic start_xfer;
        en = 1'b1;
        tick();
        chk("dreq_rise", ifc.dreq, 1);
        ifc.dack = 1'b1;
        tick();
    endtask
    initial begin
        ifc.dack = 1'b0; ifc.ior = 1'b0; ifc.iow = 1'b0; ifc.eop = 1'b0; ifc.io_din = '0;
        #2;
        chk("rst_dreq", ifc.dreq, 0);
        chk("rst_io_dout", ifc.io_dout, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        #10 rst_n = 1'b1;
        tick();
        // source burst
        dir = DIR_SRC;
        push_local(8'd5); push_local(8'd10); push_local(8'd15);
        chk("src_count", count, 3);
        start_xfer();
        strobe_rd(8'd5); strobe_rd(8'd10); strobe_rd(8'd15);
        chk("src_empty", empty, 1);
        chk("src_dreq_fall", ifc.dreq, 0);
        chk("src_hold", ifc.io_dout, 15);
        ifc.eop = 1'b1;
        tick();
        ifc.eop = 1'b0;
        chk("src_done", done, 1);
        en = 1'b0; ifc.dack = 1'b0;
        tick();
        chk("src_done_clr", done, 0);
        // sink burst
        dir = DIR_SNK;
        start_xfer();
        strobe_wr(8'h8C); strobe_wr(8'h03); strobe_wr(8'h01); strobe_wr(8'h55);
        chk("snk_full", full, 1);
        chk("snk_dreq_fall", ifc.dreq, 0);
        ifc.dack = 1'b0; en = 1'b0;
        tick(); tick();
        local_pop(8'h8C); local_pop(8'h03); local_pop(8'h01); local_pop(8'h55);
        chk("snk_empty", empty, 1);
        // EOP together with the second strobe
        dir = DIR_SRC;
        push_local(8'd1); push_local(8'd2); push_local(8'd3); push_local(8'd4);
        start_xfer();
        strobe_rd(8'd1); strobe_rd(8'd2, 1'b1);
        chk("eop_count", count, 2);
        chk("eop_dreq", ifc.dreq, 0);
        chk("eop_done", done, 1);
        en = 1'b0; ifc.dack = 1'b0;
        tick();
        chk("eop_done_clr", done, 0);
        dir = DIR_SNK;
        local_pop(8'd3); local_pop(8'd4);
        chk("eop_drained", empty, 1);
        // underrun
        dir = DIR_SRC;
        push_local(8'h20);
        start_xfer();
        strobe_rd(8'h20); strobe_rd(8'h20);
        chk("udr_count", count, 0);
        chk("udr_err", err, 1);
        ifc.dack = 1'b0;
        tick();
        en = 1'b0;
        tick();
        chk("udr_err_clr", err, 0);
        // simultaneous local push and DMAC pop on a full FIFO
        push_local(8'hA1); push_local(8'hA2); push_local(8'hA3); push_local(8'hA4);
        chk("sim_full", full, 1);
        start_xfer();
        wr_en = 1'b1; wr_data = 8'hB5;
        strobe_rd(8'hA1);
        wr_en = 1'b0;
        chk("sim_count", count, 4);
        chk("sim_err", err, 0);
        strobe_rd(8'hA2); strobe_rd(8'hA3); strobe_rd(8'hA4); strobe_rd(8'hB5);
        chk("sim_empty", empty, 1);
        ifc.eop = 1'b1;
        tick();
        ifc.eop = 1'b0; en = 1'b0; ifc.dack = 1'b0;
        tick();
        // asynchronous reset in the middle of a transfer
        push_local(8'h11); push_local(8'h22);
        start_xfer();
        chk("rstx_pre_dreq", ifc.dreq, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("rstx_dreq", ifc.dreq, 0);
        chk("rstx_count", count, 0);
        chk("rstx_empty", empty, 1);
        chk("rstx_done", done, 0);
        ifc.dack = 1'b0; en = 1'b0;
        chk("queues_drained", exp_io.size() + exp_rd.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dma_io_port.md
Name: dma_io_port

Overview:
- Peripheral-side end of the DMAC DREQ/DACK handshake: the I/O device that the DMAC serves.
- Buffers bytes in a small FIFO and requests service via DREQ.
- When the DMAC acknowledges with DACK+IOR, it sources bytes onto the DMAC data input. When the DMAC acknowledges with DACK+IOW, it sinks bytes from the DMAC data output.
- Stops requesting on EOP.
- Sits between the DMAC and a local producer/consumer; it is also the synthesizable device model for I/O<->memory single and burst benches.

Parameters:
- DATA_W, 8, data byte width (matches DMAC Data_in/Data_out).
- DEPTH, 4, FIFO entries; power of two, >=2.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- EN  in  1  enables requesting; deassert to clear DONE and return to IDLE.
- DIR  in  1  0 = source (I/O->mem, serves IOR); 1 = sink (mem->I/O, serves IOW); sampled only in IDLE.
- DREQ  out  1  DMA request to DMAC.
- DACK  in  1  DMA acknowledge from DMAC.
- IOR  in  1  DMAC I/O read strobe.
- IOW  in  1  DMAC I/O write strobe.
- EOP  in  1  end of process from DMAC.
- IO_DOUT  out  DATA_W  byte to DMAC Data_in.
- IO_DIN  in  DATA_W  byte from DMAC Data_out.
- WR_EN  in  1  local push.
- WR_DATA  in  DATA_W  local push data.
- RD_EN  in  1  local pop.
- RD_DATA  out  DATA_W  FIFO head, for the local consumer.
- FULL  out  1  count == DEPTH.
- EMPTY  out  1  count == 0.
- COUNT  out  CNT_W  occupancy.
- DONE  out  1  sticky; set on EOP.
- ERR  out  1  sticky; under/overrun.

Behaviour:
- Reset (RST=0, async):
  - State IDLE; FIFO pointers and count 0.
  - DREQ=0, IO_DOUT=0, RD_DATA=0, DONE=0, ERR=0, EMPTY=1, FULL=0, COUNT=0.
- FIFO: circular buffer with wrapping read/write pointers.
  - IO_DOUT and RD_DATA both equal mem[rd_ptr] when not empty; when empty they hold their last value.
- Service condition: svc = DIR_q ? !FULL : !EMPTY.
- Strobe: stb = DACK & (DIR_q ? IOW : IOR), qualified by state XFER.
  - Source, stb high: pop at the clock edge. The DMAC samples IO_DOUT in the same cycle.
  - Sink, stb high: IO_DIN is pushed at the edge.
- Local side:
  - Source mode: WR_EN pushes; RD_EN is ignored.
  - Sink mode: RD_EN pops; WR_EN is ignored.
- Simultaneous push and pop in one cycle: both occur and count is unchanged. This is legal even when full (source) or empty (sink): the pop/push on the DMAC side has priority in ordering.
- FSM (registered DREQ):
  - IDLE: DIR_q<=DIR. EN & svc -> REQ.
  - REQ: DREQ=1. DACK -> XFER. EOP -> TERM. !EN -> IDLE.
  - XFER: DREQ=1 while svc holds after this cycle's update, giving burst continuation.
    - Next-cycle svc false -> DREQ=0 and go to REQ-wait. Stay in XFER with DREQ=0 until svc is true again, then DREQ=1.
    - DACK low -> REQ.
  - TERM: DREQ=0, DONE=1. Stay until EN=0, then IDLE. DONE clears on entering IDLE.
- EOP in the same cycle as a strobe: the strobe's transfer completes, then TERM.
- EOP in IDLE: ignored.
- Underrun: IOR&DACK while empty (source). No pop, IO_DOUT holds, ERR<=1.
- Overrun: IOW&DACK while full (sink). Write dropped, ERR<=1.
- Local misuse sets ERR; the operation is dropped:
  - push while full, with no same-cycle pop;
  - pop while empty.
- ERR clears only on reset or on IDLE entry with EN=0.
- Latency:
  - DREQ rises 1 cycle after EN & svc.
  - DREQ falls 1 cycle after EOP or after svc is lost.

Decomposition:
- Shared package dmac_pkg: state encoding (IDLE, REQ, XFER, TERM), DIR_SRC/DIR_SNK constants, DATA_W default.
- One natural sub-module: sync_fifo (DATA_W, DEPTH; push/pop/full/empty/count/head). The FSM and handshake live in dma_io_port.

Test Plan:
- Source burst: push 5,10,15; EN=1, DIR=0.
  - Expected: DREQ=1 after 1 cycle.
  - Drive DACK=1, IOR=1 for 3 cycles: IO_DOUT=5,10,15 on successive cycles.
  - After the 3rd cycle: EMPTY=1, DREQ=0.
  - EOP pulse -> DONE=1.
- Sink burst: DIR=1, EN=1, empty FIFO -> DREQ=1.
  - DACK+IOW with IO_DIN=0x8C,0x03,0x01,0x55 -> FULL=1 and DREQ=0 after the 4th.
  - Local RD_EN x4 -> RD_DATA=0x8C,0x03,0x01,0x55.
- EOP mid-burst: source with 4 bytes; EOP together with the 2nd strobe -> COUNT=2, TERM, DREQ=0, DONE=1. EN=0 -> DONE=0.
- Underrun: source, 1 byte (0x20); two IOR strobes -> IO_DOUT=0x20 on both, COUNT=0, ERR=1.
- Simultaneous: source, full FIFO; WR_EN and an IOR strobe in the same cycle -> COUNT stays 4, ERR=0, and the new byte appears after the 3 older ones.
- Reset mid-XFER: RST=0 asynchronously -> DREQ=0, COUNT=0, EMPTY=1, DONE=0 immediately, without waiting for a clock edge.
